sync_fifo_param: RTL and testbench

//  Parametrised single-clock FIFO: successor to the fixed 16x8 FIFO. Adds generic width/depth, programmable

---
 rtl/sync_fifo_param.sv | 101 ++++++++++
 tb/tb_sync_fifo_param.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_param.sv
// Single-clock parametrised FIFO with an occupancy count, a programmable threshold and clearable
// sticky overflow/underflow flags. A read and a write in the same cycle at full are both accepted.
module sync_fifo_param #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter int THRESH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr,
  input  logic              rd,
  input  logic              clr_flags,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic [ADDR_W:0]   fifo_count,
  output logic              fifo_full,
  output logic              fifo_empty,
  output logic              fifo_threshold,
  output logic              fifo_overflow,
  output logic              fifo_underflow
);

  localparam int             DEPTH    = 1 << ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_C  = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE_C    = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0] ZERO_C   = '0;
  localparam logic [ADDR_W:0] THRESH_C = THRESH[ADDR_W:0];

  typedef enum logic [1:0] {S_EMPTY, S_PARTIAL, S_FULL} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W:0]     wptr_q, wptr_d;
  logic [ADDR_W:0]     rptr_q, rptr_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic [DATA_W-1:0]   data_q;
  logic                ovf_q, ovf_d;
  logic                unf_q, unf_d;
  logic                wr_ok, rd_ok;
  logic                st_full, st_empty;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  always_comb begin
    st_full  = (state_q == S_FULL);
    st_empty = (state_q == S_EMPTY);
    // A read frees a slot in the same edge, so a write at full is still accepted when paired with rd.
    wr_ok    = wr && (!st_full || rd);
    rd_ok    = rd && !st_empty;

    wptr_d  = wr_ok ? wptr_q + ONE_C : wptr_q;
    rptr_d  = rd_ok ? rptr_q + ONE_C : rptr_q;

    count_d = count_q;
    case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + ONE_C;
      2'b01:   count_d = count_q - ONE_C;
      default: count_d = count_q;
    endcase

    if (count_d == ZERO_C)       state_d = S_EMPTY;
    else if (count_d == DEPTH_C) state_d = S_FULL;
    else                         state_d = S_PARTIAL;

    // Setting a sticky flag takes priority over clearing it in the same cycle.
    ovf_d = (wr && st_full && !rd) || (ovf_q && !clr_flags);
    unf_d = (rd && st_empty) || (unf_q && !clr_flags);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_EMPTY;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      data_q  <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      if (rd_ok) data_q <= mem_q[rptr_q[ADDR_W-1:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && wr_ok) mem_q[wptr_q[ADDR_W-1:0]] <= data_in;
  end

  assign data_out       = data_q;
  assign fifo_count     = count_q;
  assign fifo_empty     = (wptr_q == rptr_q);
  assign fifo_full      = (wptr_q[ADDR_W] != rptr_q[ADDR_W]) &&
                          (wptr_q[ADDR_W-1:0] == rptr_q[ADDR_W-1:0]);
  assign fifo_threshold = (count_q >= THRESH_C);
  assign fifo_overflow  = ovf_q;
  assign fifo_underflow = unf_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Bench for sync_fifo_param: queue-based reference model checked every cycle, plus directed
// scenarios with literal expectations.
module tb_sync_fifo_param;

  localparam int DEPTH  = 16;
  localparam int THRESH = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr = 1'b0, rd = 1'b0, clr_flags = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic [7:0] data_out;
  logic [4:0] fifo_count;
  logic       fifo_full, fifo_empty, fifo_threshold, fifo_overflow, fifo_underflow;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  sync_fifo_param #(.DATA_W(8), .ADDR_W(4), .THRESH(THRESH)) dut (
    .clk(clk), .rst(rst), .wr(wr), .rd(rd), .clr_flags(clr_flags),
    .data_in(data_in), .data_out(data_out), .fifo_count(fifo_count),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty), .fifo_threshold(fifo_threshold),
    .fifo_overflow(fifo_overflow), .fifo_underflow(fifo_underflow)
  );

  always #5 clk = ~clk;

  // Reference model: a plain queue with the accept rules applied to the pre-edge occupancy.
  logic [7:0] m_q[$];
  logic [7:0] m_dout = 8'h00;
  bit         m_ovf = 1'b0, m_unf = 1'b0;

  always @(posedge clk) begin
    bit full_b, empty_b, do_wr, do_rd;
    if (rst) begin
      m_q.delete();
      m_dout = 8'h00;
      m_ovf  = 1'b0;
      m_unf  = 1'b0;
    end else begin
      full_b  = (m_q.size() == DEPTH);
      empty_b = (m_q.size() == 0);
      do_rd   = rd && !empty_b;
      do_wr   = wr && (!full_b || rd);
      if (do_rd) m_dout = m_q.pop_front();
      if (do_wr) m_q.push_back(data_in);
      m_ovf = (wr && full_b && !rd) || (m_ovf && !clr_flags);
      m_unf = (rd && empty_b) || (m_unf && !clr_flags);
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("m_count",  int'(fifo_count),     m_q.size());
      check("m_full",   int'(fifo_full),      int'(m_q.size() == DEPTH));
      check("m_empty",  int'(fifo_empty),     int'(m_q.size() == 0));
      check("m_thresh", int'(fifo_threshold), int'(m_q.size() >= THRESH));
      check("m_ovf",    int'(fifo_overflow),  int'(m_ovf));
      check("m_unf",    int'(fifo_underflow), int'(m_unf));
      check("m_dout",   int'(data_out),       int'(m_dout));
    end
  end

  task automatic step(input logic w, input logic r, input logic c, input logic [7:0] d,
                      input logic rs);
    wr = w; rd = r; clr_flags = c; data_in = d; rst = rs;
    @(posedge clk);
    #1;
    wr = 1'b0; rd = 1'b0; clr_flags = 1'b0; rst = 1'b0;
  endtask

  initial begin
    // 1: reset, then reset mid-fill at count 5
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    chk_en = 1'b1;
    check("rst_count", int'(fifo_count), 0);
    check("rst_empty", int'(fifo_empty), 1);
    check("rst_dout",  int'(data_out), 0);
    check("rst_flags", int'({fifo_full, fifo_threshold, fifo_overflow, fifo_underflow}), 0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 8'h31 + 8'(i), 1'b0);
    check("fill5_count", int'(fifo_count), 5);
    step(1'b1, 1'b1, 1'b1, 8'hEE, 1'b1);
    check("midrst_count", int'(fifo_count), 0);
    check("midrst_empty", int'(fifo_empty), 1);
    check("midrst_dout",  int'(data_out), 0);
    step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    check("midrst_unf",   int'(fifo_underflow), 1);
    check("midrst_dout2", int'(data_out), 0);
    step(1'b0, 1'b0, 1'b1, 8'h00, 1'b0);

    // 2: fill 0x01..0x10, then overflow
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b0, 1'b0, 8'(i + 1), 1'b0);
      check("fill_thresh", int'(fifo_threshold), int'(i + 1 >= 8));
    end
    check("fill_count", int'(fifo_count), 16);
    check("fill_full",  int'(fifo_full), 1);
    step(1'b1, 1'b0, 1'b0, 8'hFF, 1'b0);
    check("ovf_set",   int'(fifo_overflow), 1);
    check("ovf_count", int'(fifo_count), 16);

    // 3: drain in order, then underflow holds data_out
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
      check("drain_dout", int'(data_out), i + 1);
    end
    check("drain_empty", int'(fifo_empty), 1);
    step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    check("unf_set",  int'(fifo_underflow), 1);
    check("unf_dout", int'(data_out), 'h10);
    step(1'b0, 1'b0, 1'b1, 8'h00, 1'b0);

    // 4: simultaneous rd/wr at full and at empty
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 1'b0, 8'h40 + 8'(i), 1'b0);
    step(1'b1, 1'b1, 1'b0, 8'hAA, 1'b0);
    check("rw_full_dout",  int'(data_out), 'h40);
    check("rw_full_count", int'(fifo_count), 16);
    check("rw_full_ovf",   int'(fifo_overflow), 0);
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    check("rw_full_last", int'(data_out), 'hAA);
    step(1'b1, 1'b1, 1'b0, 8'h55, 1'b0);
    check("rw_empty_count", int'(fifo_count), 1);
    check("rw_empty_unf",   int'(fifo_underflow), 1);
    check("rw_empty_dout",  int'(data_out), 'hAA);
    step(1'b0, 1'b1, 1'b1, 8'h00, 1'b0);
    check("rw_empty_rd", int'(data_out), 'h55);

    // 5: wrap-around with count held at 3
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 8'h80 + 8'(i), 1'b0);
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 1'b1, 1'b0, 8'h90 + 8'(i), 1'b0);
      check("wrap_dout",  int'(data_out), (i < 3) ? ('h80 + i) : ('h90 + i - 3));
      check("wrap_count", int'(fifo_count), 3);
    end
    check("wrap_flags", int'({fifo_overflow, fifo_underflow}), 0);

    // 6: clearing sticky flags, and set winning over clear
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 1'b0, 8'hC0 + 8'(i), 1'b0);
    step(1'b1, 1'b0, 1'b0, 8'h11, 1'b0);
    check("both_set", int'({fifo_overflow, fifo_underflow}), 3);
    step(1'b0, 1'b0, 1'b1, 8'h00, 1'b0);
    check("both_clr", int'({fifo_overflow, fifo_underflow}), 0);
    step(1'b1, 1'b0, 1'b1, 8'h22, 1'b0);
    check("set_wins", int'(fifo_overflow), 1);
    check("set_wins_count", int'(fifo_count), 16);
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);

    @(negedge clk);
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
